// File: rtl/drive_mixer_ctrl.sv
// Differential drive mixer: PID offset to per-wheel duty with
// slew limiting, run/stop sequencing and bumper fault lockout.
module drive_mixer_ctrl #(
  parameter int DUTY_W     = 17,
  parameter int CTRL_W     = 18,
  parameter int MAX_OFFSET = 12288,
  parameter int SLEW_STEP  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start_toggle,
  input  logic                     bumper_hit,
  input  logic [DUTY_W-1:0]        base_duty,
  input  logic signed [CTRL_W-1:0] ctrl_in,
  output logic [DUTY_W-1:0]        duty_l,
  output logic [DUTY_W-1:0]        duty_r,
  output logic                     motor_en,
  output logic                     pid_en,
  output logic                     sample_valid,
  output logic [2:0]               state
);

  localparam int EW =
    ((DUTY_W > CTRL_W) ? DUTY_W : CTRL_W) + 2;

  localparam logic signed [CTRL_W-1:0] OFF_MAX =
    CTRL_W'(MAX_OFFSET);
  localparam logic signed [CTRL_W-1:0] OFF_MIN =
    -OFF_MAX;
  localparam logic signed [EW-1:0] DUTY_MAX =
    EW'({DUTY_W{1'b1}});
  localparam logic [DUTY_W-1:0] STEP =
    DUTY_W'(SLEW_STEP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t              state_q;
  logic [DUTY_W-1:0]   duty_l_q, duty_r_q;
  logic                motor_en_q, pid_en_q, sv_q;

  logic signed [CTRL_W-1:0] off;
  logic signed [EW-1:0]     off_x, base_x;
  logic signed [EW-1:0]     sum_r, sum_l;
  logic [DUTY_W-1:0]        tgt_l, tgt_r;
  logic [DUTY_W-1:0]        aim_l, aim_r;
  logic [DUTY_W-1:0]        duty_l_d, duty_r_d;

  function automatic logic [DUTY_W-1:0] sat(
    input logic signed [EW-1:0] v
  );
    if (v[EW-1])            return '0;
    else if (v > DUTY_MAX)  return '1;
    else                    return v[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] slew(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] aim
  );
    if (aim > cur)
      return (aim - cur > STEP) ? cur + STEP : aim;
    else
      return (cur - aim > STEP) ? cur - STEP : aim;
  endfunction

  // Clamp the offset, mix into wheel targets, slew toward them
  always_comb begin
    off = ctrl_in;
    if (ctrl_in > OFF_MAX)
      off = OFF_MAX;
    else if (ctrl_in < OFF_MIN)
      off = OFF_MIN;
    off_x  = {{(EW-CTRL_W){off[CTRL_W-1]}}, off};
    base_x = {{(EW-DUTY_W){1'b0}}, base_duty};
    sum_r  = base_x + off_x;
    sum_l  = base_x - off_x;
    tgt_r  = sat(sum_r);
    tgt_l  = sat(sum_l);
    aim_l  = (state_q == S_RAMP_DOWN) ? '0 : tgt_l;
    aim_r  = (state_q == S_RAMP_DOWN) ? '0 : tgt_r;
    duty_l_d = slew(duty_l_q, aim_l);
    duty_r_d = slew(duty_r_q, aim_r);
  end

  // Sequencer FSM with registered duty and enable outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      duty_l_q   <= '0;
      duty_r_q   <= '0;
      motor_en_q <= 1'b0;
      pid_en_q   <= 1'b0;
      sv_q       <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          duty_l_q   <= '0;
          duty_r_q   <= '0;
          motor_en_q <= start_toggle;
          pid_en_q   <= start_toggle;
          if (start_toggle)
            state_q <= S_RAMP_UP;
        end
        S_RAMP_UP, S_RUN: begin
          if (bumper_hit) begin
            state_q    <= S_FAULT;
            duty_l_q   <= '0;
            duty_r_q   <= '0;
            motor_en_q <= 1'b0;
            pid_en_q   <= 1'b0;
          end else begin
            if (tick) begin
              duty_l_q <= duty_l_d;
              duty_r_q <= duty_r_d;
              sv_q     <= (state_q == S_RUN);
            end
            if (start_toggle) begin
              state_q  <= S_RAMP_DOWN;
              pid_en_q <= 1'b0;
            end else if (tick && state_q == S_RAMP_UP &&
                         duty_l_d == tgt_l &&
                         duty_r_d == tgt_r) begin
              state_q <= S_RUN;
            end
          end
        end
        S_RAMP_DOWN: begin
          if (bumper_hit) begin
            state_q    <= S_FAULT;
            duty_l_q   <= '0;
            duty_r_q   <= '0;
            motor_en_q <= 1'b0;
            pid_en_q   <= 1'b0;
          end else begin
            if (tick) begin
              duty_l_q <= duty_l_d;
              duty_r_q <= duty_r_d;
            end
            if (start_toggle) begin
              state_q  <= S_RAMP_UP;
              pid_en_q <= 1'b1;
            end else if (tick && duty_l_d == '0 &&
                         duty_r_d == '0) begin
              state_q    <= S_IDLE;
              motor_en_q <= 1'b0;
            end
          end
        end
        S_FAULT: begin
          duty_l_q   <= '0;
          duty_r_q   <= '0;
          motor_en_q <= 1'b0;
          pid_en_q   <= 1'b0;
          if (start_toggle && !bumper_hit)
            state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          duty_l_q   <= '0;
          duty_r_q   <= '0;
          motor_en_q <= 1'b0;
          pid_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign duty_l       = duty_l_q;
  assign duty_r       = duty_r_q;
  assign motor_en     = motor_en_q;
  assign pid_en       = pid_en_q;
  assign sample_valid = sv_q;
  assign state        = state_q;

endmodule

// File: tb/tb_drive_mixer_ctrl.sv
// Bench for drive_mixer_ctrl: vector table, directed corner
// sequences, and random stimulus against a reference model.
module tb_drive_mixer_ctrl;

  localparam int DW   = 17;
  localparam int CW   = 18;
  localparam int MO   = 12288;
  localparam int SS   = 1024;
  localparam int DMAX = (1 << DW) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tick, start_toggle, bumper_hit;
  logic [DW-1:0]        base_duty;
  logic signed [CW-1:0] ctrl_in;
  logic [DW-1:0]        duty_l, duty_r;
  logic                 motor_en, pid_en, sample_valid;
  logic [2:0]           state;

  drive_mixer_ctrl #(
    .DUTY_W(DW), .CTRL_W(CW),
    .MAX_OFFSET(MO), .SLEW_STEP(SS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .start_toggle(start_toggle),
    .bumper_hit(bumper_hit),
    .base_duty(base_duty), .ctrl_in(ctrl_in),
    .duty_l(duty_l), .duty_r(duty_r),
    .motor_en(motor_en), .pid_en(pid_en),
    .sample_valid(sample_valid), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 idle,1 up,2 run,3 down,4 fault
  int ms, mdl, mdr, men, mpid, msv;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int toward(int a, int t);
    return a + clampi(t - a, -SS, SS);
  endfunction

  task automatic model_reset();
    ms = 0; mdl = 0; mdr = 0;
    men = 0; mpid = 0; msv = 0;
  endtask

  task automatic model_step();
    int off, tl, tr;
    off = clampi(int'(ctrl_in), -MO, MO);
    tr  = clampi(int'(base_duty) + off, 0, DMAX);
    tl  = clampi(int'(base_duty) - off, 0, DMAX);
    msv = 0;
    case (ms)
      0: if (start_toggle) begin ms = 1; men = 1; end
      1, 2: begin
        if (bumper_hit) begin
          ms = 4; mdl = 0; mdr = 0; men = 0;
        end else begin
          if (tick) begin
            mdl = toward(mdl, tl);
            mdr = toward(mdr, tr);
            if (ms == 2) msv = 1;
          end
          if (start_toggle) ms = 3;
          else if (tick && ms == 1 &&
                   mdl == tl && mdr == tr) ms = 2;
        end
      end
      3: begin
        if (bumper_hit) begin
          ms = 4; mdl = 0; mdr = 0; men = 0;
        end else begin
          if (tick) begin
            mdl = toward(mdl, 0);
            mdr = toward(mdr, 0);
          end
          if (start_toggle) ms = 1;
          else if (tick && mdl == 0 && mdr == 0) begin
            ms = 0; men = 0;
          end
        end
      end
      default:
        if (start_toggle && !bumper_hit) ms = 0;
    endcase
    mpid = (ms == 1 || ms == 2) ? 1 : 0;
  endtask

  task automatic cyc(input bit t, input bit s,
                     input bit b);
    tick = t; start_toggle = s; bumper_hit = b;
    @(posedge clk);
    model_step();
    #1;
    tick = 1'b0; start_toggle = 1'b0;
    bumper_hit = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick = 1'b0; start_toggle = 1'b0;
    bumper_hit = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, int'(state), ms);
    chk({tag, ".duty_l"}, int'(duty_l), mdl);
    chk({tag, ".duty_r"}, int'(duty_r), mdr);
    chk({tag, ".motor_en"}, int'(motor_en), men);
    chk({tag, ".pid_en"}, int'(pid_en), mpid);
    chk({tag, ".sv"}, int'(sample_valid), msv);
  endtask

  typedef struct {
    bit t, s, b;
    int base, ctrl;
    int st, dl, dr, en, pid, sv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int cnt;
    int prev_r;
    bit wrapped;
    bit bump;

    tbl[0]  = '{0,0,0,16384,    0, 0,    0,    0,0,0,0};
    tbl[1]  = '{0,1,0,16384,    0, 1,    0,    0,1,1,0};
    tbl[2]  = '{1,0,0,16384,    0, 1, 1024, 1024,1,1,0};
    tbl[3]  = '{1,0,0,16384,  100, 1, 2048, 2048,1,1,0};
    tbl[4]  = '{0,0,0,16384,-5000, 1, 2048, 2048,1,1,0};
    tbl[5]  = '{1,1,0,16384,    0, 3, 3072, 3072,1,0,0};
    tbl[6]  = '{1,0,0,16384,    0, 3, 2048, 2048,1,0,0};
    tbl[7]  = '{1,0,0,16384,    0, 3, 1024, 1024,1,0,0};
    tbl[8]  = '{1,0,0,16384,    0, 0,    0,    0,0,0,0};
    tbl[9]  = '{0,1,0,16384,    0, 1,    0,    0,1,1,0};
    tbl[10] = '{0,0,1,16384,    0, 4,    0,    0,0,0,0};
    tbl[11] = '{0,1,1,16384,    0, 4,    0,    0,0,0,0};
    tbl[12] = '{0,1,0,16384,    0, 0,    0,    0,0,0,0};

    base_duty = '0; ctrl_in = '0;
    do_reset();
    chk("reset.state", int'(state), 0);
    chk("reset.duty_l", int'(duty_l), 0);
    chk("reset.motor_en", int'(motor_en), 0);

    for (int i = 0; i < 13; i++) begin
      base_duty = DW'(tbl[i].base);
      ctrl_in   = CW'(tbl[i].ctrl);
      cyc(tbl[i].t, tbl[i].s, tbl[i].b);
      chk($sformatf("vec%0d.state", i), int'(state),
          tbl[i].st);
      chk($sformatf("vec%0d.duty_l", i), int'(duty_l),
          tbl[i].dl);
      chk($sformatf("vec%0d.duty_r", i), int'(duty_r),
          tbl[i].dr);
      chk($sformatf("vec%0d.motor_en", i),
          int'(motor_en), tbl[i].en);
      chk($sformatf("vec%0d.pid_en", i), int'(pid_en),
          tbl[i].pid);
      chk($sformatf("vec%0d.sv", i),
          int'(sample_valid), tbl[i].sv);
    end

    // ramp-up from idle
    do_reset();
    base_duty = DW'(16384); ctrl_in = '0;
    cyc(0, 1, 0);
    chk("ramp.start_state", int'(state), 1);
    chk("ramp.start_en", int'(motor_en), 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0);
      chk($sformatf("ramp.l%0d", k), int'(duty_l),
          k * 1024);
      chk($sformatf("ramp.r%0d", k), int'(duty_r),
          k * 1024);
      chk($sformatf("ramp.st%0d", k), int'(state),
          (k < 16) ? 1 : 2);
      cyc(0, 0, 0);
    end

    // clamp in RUN
    ctrl_in = CW'(20000);
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 0, 0);
      cnt += int'(sample_valid);
      chk($sformatf("clamp.r%0d", k), int'(duty_r),
          16384 + k * 1024);
      cyc(0, 0, 0);
      chk("clamp.sv_gap", int'(sample_valid), 0);
    end
    chk("clamp.tgt_r", int'(duty_r), 28672);
    chk("clamp.tgt_l", int'(duty_l), 4096);
    chk("clamp.sv_count", cnt, 12);

    // back to 16384, then ramp down to idle
    ctrl_in = '0;
    for (int k = 0; k < 12; k++) cyc(1, 0, 0);
    chk("down.pre_l", int'(duty_l), 16384);
    cyc(0, 1, 0);
    chk("down.state", int'(state), 3);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0);
      chk($sformatf("down.l%0d", k), int'(duty_l),
          16384 - k * 1024);
    end
    chk("down.idle", int'(state), 0);
    chk("down.en", int'(motor_en), 0);

    // reverse mid ramp-down
    cyc(0, 1, 0);
    for (int k = 0; k < 16; k++) cyc(1, 0, 0);
    chk("rev.run", int'(state), 2);
    cyc(0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    chk("rev.mid", int'(duty_r), 11264);
    cyc(0, 1, 0);
    chk("rev.up", int'(state), 1);
    cyc(1, 0, 0);
    chk("rev.step", int'(duty_r), 12288);

    // saturation
    base_duty = DW'(126000); ctrl_in = CW'(12288);
    prev_r = int'(duty_r);
    wrapped = 1'b0;
    for (int k = 0; k < 200 && state != 3'd2; k++) begin
      cyc(1, 0, 0);
      if (int'(duty_r) < prev_r) wrapped = 1'b1;
      prev_r = int'(duty_r);
    end
    chk("sat.state", int'(state), 2);
    chk("sat.r", int'(duty_r), 131071);
    chk("sat.l", int'(duty_l), 113712);
    chk("sat.nowrap", int'(wrapped), 0);

    // bumper fault
    do_reset();
    base_duty = DW'(16384); ctrl_in = '0;
    cyc(0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("bump.state", int'(state), 4);
    chk("bump.l", int'(duty_l), 0);
    chk("bump.r", int'(duty_r), 0);
    chk("bump.en", int'(motor_en), 0);
    cyc(0, 1, 1);
    chk("bump.ignored", int'(state), 4);
    cyc(0, 1, 0);
    chk("bump.release", int'(state), 0);

    // async reset mid-RUN
    cyc(0, 1, 0);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0);
    chk("arst.run", int'(state), 2);
    #2 reset = 1'b1;
    #1;
    chk("arst.state", int'(state), 0);
    chk("arst.l", int'(duty_l), 0);
    chk("arst.r", int'(duty_r), 0);
    chk("arst.en", int'(motor_en), 0);
    chk("arst.pid", int'(pid_en), 0);
    tick = 1'b1; start_toggle = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.hold", int'(state), 0);
    tick = 1'b0; start_toggle = 1'b0;
    model_reset();
    reset = 1'b0;

    // random stimulus vs model
    bump = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0)
        base_duty = ($urandom_range(1) == 0) ?
          DW'($urandom_range(DMAX)) :
          DW'($urandom_range(40000, 10000));
      if ($urandom_range(3) == 0)
        ctrl_in = CW'(int'($urandom_range(60000)) - 30000);
      if (!bump && $urandom_range(60) == 0) bump = 1'b1;
      else if (bump && $urandom_range(3) == 0) bump = 1'b0;
      cyc($urandom_range(2) == 0,
          $urandom_range(40) == 0, bump);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
